// File: rtl/zrb_uart_link.sv
// rtl/zrb_uart_link.sv - dual-rate UART link: baud generator, 8x RX, TX and RX/TX FIFOs
module zrb_uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_wr, do_rd;

    always_comb begin
        full     = count_q[AW];
        empty    = (count_q == '0);
        do_wr    = wr && (!full || rd);
        do_rd    = rd && !empty;
        rd_next  = rd_ptr_q + AW'(1);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_next : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
        // Registered head gives first-word fall-through one cycle after a pop or first push.
        head_d = head_q;
        if (do_rd) begin
            if (count_q > (AW+1)'(1)) begin
                head_d = mem_q[rd_next];
            end else if (do_wr) begin
                head_d = wdata;
            end
        end else if (do_wr && empty) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign level = count_q;
endmodule

module zrb_uart_link #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_0    = 9600,
    parameter int BAUD_1    = 115200,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 speed_select,
    output logic                 speed_active,
    input  logic                 bt_rx,
    output logic                 bt_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_write,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_read,
    output logic [FIFO_AW:0]     rx_level,
    output logic [FIFO_AW:0]     tx_level,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clear
);
    localparam int DIV0    = CLK_FREQ / (8 * BAUD_0);
    localparam int DIV1    = CLK_FREQ / (8 * BAUD_1);
    localparam int DIV_MAX = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int CW      = $clog2(DIV_MAX);
    localparam int BW      = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST0    = CW'(DIV0 - 1);
    localparam logic [CW-1:0] LAST1    = CW'(DIV1 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    generate
        if (DIV0 < 2 || DIV1 < 2) begin : g_bad_div
            $error("zrb_uart_link: baud divider below 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("zrb_uart_link: DATA_BITS out of range 5..9");
        end
    endgenerate

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [CW-1:0]        div_cnt_q, div_cnt_d;
    logic [2:0]           phase_q, phase_d;
    logic                 speed_active_q, speed_active_d;
    logic                 rx_meta_q, rxs_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [2:0]           rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bits_q, rx_bits_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    tx_state_t            tx_state_q, tx_state_d;
    logic [BW-1:0]        tx_bits_q, tx_bits_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 bt_tx_q, bt_tx_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 tick8, bit_tick, rate_switch;
    logic                 rx_push, frame_set, over_set, rx_full, rx_empty;
    logic                 tx_pop, tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    always_comb begin
        tick8       = (div_cnt_q == (speed_active_q ? LAST1 : LAST0));
        bit_tick    = tick8 && (phase_q == 3'd7);
        rate_switch = (rx_state_q == RX_IDLE) && (tx_state_q == TX_IDLE) &&
                      (speed_select != speed_active_q);
        speed_active_d = rate_switch ? speed_select : speed_active_q;
        // Restart both dividers on a switch so the new rate begins on a clean boundary.
        if (rate_switch || tick8) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
        if (rate_switch) begin
            phase_d = '0;
        end else if (tick8) begin
            phase_d = phase_q + 3'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        over_set   = 1'b0;
        if (tick8) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rxs_q) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 3'd3) begin
                        rx_cnt_d   = '0;
                        rx_bits_d  = '0;
                        rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 3'd1;
                    end
                end
                RX_DATA: begin
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) begin
                        rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bits_d  = rx_bits_q + BW'(1);
                        if (rx_bits_q == LAST_BIT) begin
                            rx_state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) begin
                        rx_state_d = RX_IDLE;
                        if (!rxs_q) begin
                            frame_set = 1'b1;
                        end else if (rx_full) begin
                            over_set = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        bt_tx_d    = bt_tx_q;
        tx_pop     = 1'b0;
        if (bit_tick) begin
            case (tx_state_q)
                TX_START: begin
                    bt_tx_d    = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bits_d  = '0;
                    tx_state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bits_q == LAST_BIT) begin
                        bt_tx_d    = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        bt_tx_d    = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bits_d  = tx_bits_q + BW'(1);
                    end
                end
                default: begin
                    // IDLE and the end of STOP both launch the next queued byte directly.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        bt_tx_d    = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        frame_err_d = err_clear ? 1'b0 : (frame_err_q | frame_set);
        overrun_d   = err_clear ? 1'b0 : (overrun_q | over_set);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q      <= '0;
            phase_q        <= '0;
            speed_active_q <= 1'b0;
            rx_meta_q      <= 1'b1;
            rxs_q          <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bits_q      <= '0;
            rx_shift_q     <= '0;
            tx_state_q     <= TX_IDLE;
            tx_bits_q      <= '0;
            tx_shift_q     <= '0;
            bt_tx_q        <= 1'b1;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            phase_q        <= phase_d;
            speed_active_q <= speed_active_d;
            rx_meta_q      <= bt_rx;
            rxs_q          <= rx_meta_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bits_q      <= rx_bits_d;
            rx_shift_q     <= rx_shift_d;
            tx_state_q     <= tx_state_d;
            tx_bits_q      <= tx_bits_d;
            tx_shift_q     <= tx_shift_d;
            bt_tx_q        <= bt_tx_d;
            frame_err_q    <= frame_err_d;
            overrun_q      <= overrun_d;
        end
    end

    zrb_uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (rx_push),
        .wdata   (rx_shift_q),
        .rd      (rx_read),
        .rdata   (rx_data),
        .level   (rx_level),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    zrb_uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (tx_write),
        .wdata   (tx_data),
        .rd      (tx_pop),
        .rdata   (tx_head),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign speed_active = speed_active_q;
    assign bt_tx        = bt_tx_q;
    assign tx_busy      = (tx_state_q != TX_IDLE);
    assign rx_valid     = !rx_empty;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
endmodule
